dff_wall_write_arbiter: RTL and testbench

Shares a small bank of 10-bit enable-DFF registers (tag/index holding entries in the out-of-order core) between several writers that contend for a single write port. Each cycle it:
- picks one requester round-robin,
- drives that entry's register enable with the winner's data,
- tracks a per-entry valid bit and services an invalidate port,
- exposes one combinational read port.

---
 rtl/dff_wall_write_arbiter_pkg.sv | 8 +
 rtl/dff_wall_write_arbiter_rr_arbiter.sv | 29 ++
 rtl/wallOfDFFsL10.sv | 15 +
 rtl/dff_wall_write_arbiter.sv | 92 +++++++++
 tb/tb_dff_wall_write_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dff_wall_write_arbiter_pkg.sv
// Shared constants and types for the register-wall write arbiter.
package dff_wall_write_arbiter_pkg;
  localparam int WIDTH_DEF   = 10;
  localparam int ENTRIES_DEF = 4;
  localparam int REQS_DEF    = 3;

  typedef logic [$clog2(ENTRIES_DEF)-1:0] entry_addr_t;
endpackage

// File: rtl/dff_wall_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first request at or above ptr_i wins, wrapping around.
module rr_arbiter #(
  parameter int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // Upper half of the ring [ptr..N-1] first, then the wrapped part [0..ptr-1].
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i < int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wallOfDFFsL10.sv
// Bank of enable flip-flops with synchronous active-high clear.
module wallOfDFFsL10 #(
  parameter int LENGTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LENGTH-1:0] d,
  output logic [LENGTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (enable) q <= d;
  end
endmodule

// File: rtl/dff_wall_write_arbiter.sv
// Shared enable-DFF register bank with a single round-robin arbitrated write port,
// per-entry valid bits, an invalidate port and a combinational read port.
module dff_wall_write_arbiter
  import dff_wall_write_arbiter_pkg::*;
#(
  parameter int  WIDTH   = WIDTH_DEF,
  parameter int  ENTRIES = ENTRIES_DEF,
  parameter int  REQS    = REQS_DEF,
  localparam int AW      = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQS-1:0]       req,
  input  logic [REQS*AW-1:0]    req_addr,
  input  logic [REQS*WIDTH-1:0] req_data,
  output logic [REQS-1:0]       gnt,
  input  logic                  inv_en,
  input  logic [AW-1:0]         inv_addr,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [ENTRIES-1:0]    valid
);
  localparam int PW = $clog2(REQS);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [REQS-1:0]    arb_gnt;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic [ENTRIES-1:0] vld_d;
  logic               vld_en;
  logic [WIDTH-1:0]   ent_q [ENTRIES];

  rr_arbiter #(.N(REQS)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // Grants are suppressed during reset so a pending request cannot write.
  assign gnt = reset ? '0 : arb_gnt;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    ptr_d   = ptr_q;
    for (int i = 0; i < REQS; i++) begin
      if (gnt[i]) begin
        wr_en   = 1'b1;
        wr_addr = req_addr[i*AW +: AW];
        wr_data = req_data[i*WIDTH +: WIDTH];
        ptr_d   = (i == REQS - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    wallOfDFFsL10 #(.LENGTH(WIDTH)) u_ent (
      .clk    (clk),
      .reset  (reset),
      .enable (wr_en && (wr_addr == AW'(e))),
      .d      (wr_data),
      .q      (ent_q[e])
    );
  end

  // Set after clear so a write beats an invalidate to the same entry.
  always_comb begin
    vld_d  = valid;
    vld_en = wr_en | inv_en;
    if (inv_en) vld_d[inv_addr] = 1'b0;
    if (wr_en)  vld_d[wr_addr]  = 1'b1;
  end

  wallOfDFFsL10 #(.LENGTH(ENTRIES)) u_valid (
    .clk    (clk),
    .reset  (reset),
    .enable (vld_en),
    .d      (vld_d),
    .q      (valid)
  );

  assign rd_data  = ent_q[rd_addr];
  assign rd_valid = valid[rd_addr];
endmodule

// File: tb/tb_dff_wall_write_arbiter.sv
// Directed bench for dff_wall_write_arbiter with hand-computed expectations.
module tb_dff_wall_write_arbiter;
  import dff_wall_write_arbiter_pkg::*;

  localparam int WIDTH   = WIDTH_DEF;
  localparam int ENTRIES = ENTRIES_DEF;
  localparam int REQS    = REQS_DEF;
  localparam int AW      = $clog2(ENTRIES);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [REQS-1:0]       req;
  logic [REQS*AW-1:0]    req_addr;
  logic [REQS*WIDTH-1:0] req_data;
  logic [REQS-1:0]       gnt;
  logic                  inv_en;
  entry_addr_t           inv_addr;
  entry_addr_t           rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic [ENTRIES-1:0]    valid;

  int checks   = 0;
  int failures = 0;

  dff_wall_write_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .inv_en   (inv_en),
    .inv_addr (inv_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .valid    (valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance to the next negedge (one posedge passes), then let inputs settle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    req_addr[idx*AW +: AW]       = addr;
    req_data[idx*WIDTH +: WIDTH] = data;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    next_cycle();
    reset = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    inv_en   = 1'b0;
    inv_addr = '0;
    rd_addr  = '0;

    // Mid-handshake reset: req1 pending while reset is held.
    set_req(1, 2'd0, 10'h155);
    req = 3'b010;
    next_cycle(); settle();
    check("rst_gnt",     32'(gnt),      'b000);
    check("rst_valid",   32'(valid),    'b0000);
    check("rst_rd_data", 32'(rd_data),  'h0);
    check("rst_rd_vld",  32'(rd_valid), 'h0);
    next_cycle(); settle();
    check("rst_nowrite", 32'(valid),    'b0000);
    check("rst_gnt2",    32'(gnt),      'b000);
    reset = 1'b0; settle();
    check("post_rst_gnt", 32'(gnt), 'b010);
    next_cycle();
    req = '0; rd_addr = 2'd0; settle();
    check("post_rst_data",  32'(rd_data), 'h155);
    check("post_rst_valid", 32'(valid),   'b0001);

    // Single write from requester 0 after a fresh reset.
    apply_reset();
    settle();
    check("rst2_valid", 32'(valid), 'b0000);
    set_req(0, 2'd2, 10'h2A5);
    req = 3'b001; settle();
    check("single_gnt", 32'(gnt), 'b001);
    rd_addr = 2'd2; settle();
    check("single_no_bypass", 32'(rd_valid), 'h0);
    next_cycle();
    req = '0; settle();
    check("single_data",  32'(rd_data),  'h2A5);
    check("single_rdvld", 32'(rd_valid), 'h1);
    check("single_valid", 32'(valid),    'b0100);

    // All-request rotation from ptr=0.
    apply_reset();
    set_req(0, 2'd0, 10'h011);
    set_req(1, 2'd1, 10'h022);
    set_req(2, 2'd3, 10'h033);
    req = 3'b111; settle();
    check("rot_gnt0", 32'(gnt), 'b001); next_cycle(); settle();
    check("rot_gnt1", 32'(gnt), 'b010); next_cycle(); settle();
    check("rot_gnt2", 32'(gnt), 'b100); next_cycle(); settle();
    check("rot_gnt3", 32'(gnt), 'b001); next_cycle(); settle();
    check("rot_gnt4", 32'(gnt), 'b010); next_cycle(); settle();
    check("rot_gnt5", 32'(gnt), 'b100); next_cycle();
    req = '0; rd_addr = 2'd3; settle();
    check("rot_valid", 32'(valid),   'b1011);
    check("rot_data3", 32'(rd_data), 'h033);
    rd_addr = 2'd1; settle();
    check("rot_data1", 32'(rd_data), 'h022);

    // Pointer skip: grant 0, then 101 -> 2, then 001 still held -> 0.
    req = 3'b001; settle();
    check("skip_gnt0", 32'(gnt), 'b001); next_cycle();
    req = 3'b101; settle();
    check("skip_gnt2", 32'(gnt), 'b100); next_cycle();
    req = 3'b001; settle();
    check("skip_gnt0b", 32'(gnt), 'b001); next_cycle();
    req = '0; settle();
    check("skip_idle", 32'(gnt), 'b000);

    // Same-entry race from ptr=0: last writer wins.
    apply_reset();
    set_req(0, 2'd1, 10'h111);
    set_req(1, 2'd1, 10'h222);
    req = 3'b011; rd_addr = 2'd1; settle();
    check("race_gnt0", 32'(gnt), 'b001); next_cycle();
    req = 3'b010; settle();
    check("race_data1", 32'(rd_data), 'h111);
    check("race_gnt1",  32'(gnt),     'b010); next_cycle();
    req = '0; settle();
    check("race_data2", 32'(rd_data), 'h222);

    // Write/invalidate collision on entry 3 (ptr=2, so requester 2 writes).
    set_req(2, 2'd3, 10'h3FF);
    req = 3'b100; inv_en = 1'b1; inv_addr = 2'd3; rd_addr = 2'd3; settle();
    check("coll_gnt", 32'(gnt), 'b100); next_cycle();
    req = '0; settle();
    check("coll_rdvld", 32'(rd_valid), 'h1);
    check("coll_data",  32'(rd_data),  'h3FF);
    next_cycle();
    inv_en = 1'b0; settle();
    check("inv_rdvld", 32'(rd_valid), 'h0);
    check("inv_data",  32'(rd_data),  'h3FF);
    check("inv_valid", 32'(valid),    'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
